mpc_encoder: RTL
================

# mpc_encoder

Issue-side companion to the combinational micro-operation datapath (`mpc`). It accepts abstract arithmetic requests (op, A, B) through a valid/ready port and buffers them in a small FIFO. It encodes each request into the 18-bit micro-instruction format, drives it to the datapath, captures the 9-bit result, and returns it, in order, through a valid/ready response port.

## Interface
- `DEPTH`, 4: request FIFO depth; power of two, ≥ 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept; equals `count != DEPTH`.
- `req_op` in 2: 0 = ADD, 1 = SUB, 2 = INC, 3 = DEC.
- `req_a` in 8: operand 1.
- `req_b` in 8: operand 2; ignored for INC/DEC.
- `instr_out` out 18: encoded micro-instruction to the datapath; registered.
- `mpc_out` in 9: datapath result; combinational function of `instr_out`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_result` out 9: captured result.
- `rsp_instr` out 18: instruction that produced `rsp_result`.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: high when state is not IDLE or `count != 0`.

## Operation
- Encoding: `instr[17:16]` = `req_op`; `instr[7:0]` = `req_a`.
  - `instr[15:8]` = `req_b` for ADD/SUB.
  - `instr[15:8]` = 8'h00 for INC/DEC. This field is forced to zero, never passed through.
- Request push: at an edge where `req_valid && req_ready`. The entry is stored pre-encoded (18 bits).
- `req_ready` depends only on `count`. No push is allowed while full, even on a pop cycle.
- FSM states:
  - IDLE: if `count != 0`, pop the head, `instr_out <= head`, go to ISSUE.
  - ISSUE: `rsp_result <= mpc_out`, `rsp_instr <= instr_out`, `rsp_valid <= 1`, go to RESP.
  - RESP: hold all outputs until `rsp_valid && rsp_ready`. Then clear `rsp_valid`.
    - If `count != 0`, pop and load `instr_out` in the same edge and go to ISSUE.
    - Otherwise go to IDLE.
- Push and pop in the same edge: `count` unchanged. Pointers wrap modulo DEPTH.
- Responses are strictly in request order. None are dropped or duplicated.
- `instr_out` holds its last value while idle.
- No arithmetic is performed in this block; the result comes entirely from `mpc_out`.
- Reset values: `instr_out` = 0, `rsp_result` = 0, `rsp_instr` = 0, `rsp_valid` = 0, `count` = 0, state = IDLE. `req_ready` = 1 after reset, `busy` = 0.
- Reset mid-operation flushes the FIFO and any in-flight or unacknowledged response. Nothing is replayed.

## Timing
- Accept at edge E0 with the block idle and empty:
  - E1: pop; `instr_out` is valid after E1.
  - E2: capture; `rsp_valid` is high after E2.
- Back-to-back throughput with `rsp_ready` held at 1 is one result per 2 cycles.
- `mpc_out` is sampled exactly one cycle after `instr_out` changes. The datapath must settle within one cycle.
- `rsp_result` and `rsp_instr` are stable while `rsp_valid && !rsp_ready`.
- Capacity before `req_ready` drops: DEPTH entries in the FIFO plus one in flight.

## Structure
- Package `mpc_pkg` holds:
  - the op enum (ADD/SUB/INC/DEC = 2'd0..3)
  - `INSTR_W` = 18, `OPND_W` = 8, `RES_W` = 9
  - field position constants: CODE [17:16], OPR2 [15:8], OPR1 [7:0]
  - an `encode` function.
- Sub-module `mpc_req_fifo`: synchronous FIFO with parameters DEPTH and WIDTH = `INSTR_W`. It provides full, empty and count outputs. The FSM and encoder stay in the top level.
- The bench instantiates `mpc` driven by `instr_out` and feeding `mpc_out`.

## Test plan
- ADD A=8'h7F, B=8'h01 with `rsp_ready`=1 → `instr_out` = 18'h0017F, `rsp_result` = 9'h080, `rsp_valid` high 2 edges after acceptance.
- SUB A=8'h05, B=8'h07 → `instr_out` = 18'h10705, `rsp_result` = 9'h1FE.
- INC A=8'hFF, B=8'hAB → `instr_out` = 18'h200FF (B masked to zero), `rsp_result` = 9'h100.
- DEC A=8'h00 → `instr_out` = 18'h30000, `rsp_result` = 9'h1FF.
- Backpressure, DEPTH=4: hold `rsp_ready`=0 and push 6 ADDs with A=1..6, B=0.
  - Expected: 5 accepted, `req_ready` low once `count`=4, sixth request held.
  - Then release `rsp_ready`: results 1..6 arrive in order, one every 2 cycles.
- Reset mid-operation: assert `rst` for one cycle while in RESP with `count`=3.
  - Expected next cycle: `rsp_valid`=0, `count`=0, `instr_out`=0, `busy`=0.
  - A new request completes normally.

Source files
------------

// File: rtl/mpc_pkg.sv
// Shared definitions for the mpc micro-instruction format and its issue logic.
package mpc_pkg;

  localparam int INSTR_W = 18;
  localparam int OPND_W  = 8;
  localparam int RES_W   = 9;

  // Field positions inside the 18-bit micro-instruction.
  localparam int CODE_MSB = 17;
  localparam int CODE_LSB = 16;
  localparam int OPR2_MSB = 15;
  localparam int OPR2_LSB = 8;
  localparam int OPR1_MSB = 7;
  localparam int OPR1_LSB = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_INC = 2'd2,
    OP_DEC = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Build a micro-instruction; unary ops get a zero second operand so stale
  // request data never leaks into the datapath.
  function automatic logic [INSTR_W-1:0] encode(input op_e               op,
                                                input logic [OPND_W-1:0] a,
                                                input logic [OPND_W-1:0] b);
    logic [INSTR_W-1:0] instr;
    instr                     = '0;
    instr[CODE_MSB:CODE_LSB]  = op;
    instr[OPR1_MSB:OPR1_LSB]  = a;
    if (op == OP_ADD || op == OP_SUB) begin
      instr[OPR2_MSB:OPR2_LSB] = b;
    end
    return instr;
  endfunction

endpackage

// File: rtl/mpc.sv
// Combinational micro-operation datapath: decodes an instruction and produces
// a 9-bit result (bit 8 is carry/borrow out).
module mpc
  import mpc_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [RES_W-1:0]   result
);

  logic [RES_W-1:0] opr1;
  logic [RES_W-1:0] opr2;

  assign opr1 = {1'b0, instr[OPR1_MSB:OPR1_LSB]};
  assign opr2 = {1'b0, instr[OPR2_MSB:OPR2_LSB]};

  // Select the arithmetic function named by the code field.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    result = '0;
    case (op_e'(instr[CODE_MSB:CODE_LSB]))
      OP_ADD:  result = opr1 + opr2;
      OP_SUB:  result = opr1 - opr2;
      OP_INC:  result = opr1 + RES_W'(1);
      OP_DEC:  result = opr1 - RES_W'(1);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mpc_req_fifo.sv
// Synchronous request FIFO holding pre-encoded micro-instructions.
module mpc_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Storage write.
  // NOTE: the array carries no reset; the pointers and count define which
  // entries are meaningful, so clearing data would only add flops and muxes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mpc_encoder.sv
// Issue-side companion to the mpc datapath: buffers requests, drives encoded
// instructions one at a time, captures results and returns them in order.
module mpc_encoder
  import mpc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [OPND_W-1:0]      req_a,
  input  logic [OPND_W-1:0]      req_b,
  output logic [INSTR_W-1:0]     instr_out,
  input  logic [RES_W-1:0]       mpc_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [RES_W-1:0]       rsp_result,
  output logic [INSTR_W-1:0]     rsp_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  state_e             state;
  state_e             state_next;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic [INSTR_W-1:0] req_instr;
  logic               push;
  logic               pop;
  logic               capture;
  logic               release_rsp;

  // Readiness is a pure function of occupancy: a pop in the same cycle does
  // not open a slot for a push.
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign req_instr = encode(op_e'(req_op), req_a, req_b);
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  mpc_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (req_instr),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-edge control: IDLE pops, ISSUE captures, RESP waits
  // for the consumer and may chain straight into the next issue.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture    = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid && rsp_ready) begin
          release_rsp = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Instruction and response registers; the datapath result is sampled one
  // cycle after instr_out changes, giving it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out  <= '0;
      rsp_result <= '0;
      rsp_instr  <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      if (pop) begin
        instr_out <= fifo_head;
      end
      if (capture) begin
        rsp_result <= mpc_out;
        rsp_instr  <= instr_out;
        rsp_valid  <= 1'b1;
      end else if (release_rsp) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule
